// File: rtl/dmem_pkg.sv
// Shared decode types and MMIO register map for the data-memory responder.
package dmem_pkg;

    localparam logic [3:0] OFF_CYCLE   = 4'h0;
    localparam logic [3:0] OFF_TOHOST  = 4'h4;
    localparam logic [3:0] OFF_SCRATCH = 4'h8;
    localparam logic [3:0] OFF_STATUS  = 4'hC;

    localparam int STATUS_HALT_BIT = 0;
    localparam int STATUS_ERR_BIT  = 1;

    typedef enum logic [1:0] {
        HIT_RAM,
        HIT_MMIO,
        MISS
    } hit_e;

    function automatic logic [31:0] statusWord(input logic halt, input logic err);
        logic [31:0] w;
        w                  = '0;
        w[STATUS_HALT_BIT] = halt;
        w[STATUS_ERR_BIT]  = err;
        return w;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage bus between the pipeline (master) and the data-memory responder (slave).
interface dmem_responder_if;

    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;

    modport master (
        output MemWriteM,
        output ALUResultM,
        output WriteDataM,
        input  ReadDataM
    );

    modport slave (
        input  MemWriteM,
        input  ALUResultM,
        input  WriteDataM,
        output ReadDataM
    );

endinterface

// File: rtl/dmem_ram.sv
// Word-wide RAM with one asynchronous read port and one synchronous write port.
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_index,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // Contents are deliberately not reset; simulation preloads them.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_index] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_index];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO window (cycle counter, tohost, scratch, status).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    output logic             halt,
    output logic [31:0]      tohost,
    output logic             err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_SPAN = 33'(DEPTH_WORDS) << 2;

    logic [31:0]   w_wordAddr;
    logic [32:0]   w_ramOffset;
    logic [AW-1:0] w_ramIndex;
    logic [3:0]    w_mmioOff;
    logic          w_unused;
    hit_e          w_hit;
    logic          w_storeRam;
    logic          w_storeCycle;
    logic          w_storeTohost;
    logic          w_storeScratch;
    logic          w_storeMiss;
    logic [31:0]   w_ramRdata;
    logic [31:0]   w_readData;

    logic [31:0]   r_cycle;
    logic [31:0]   r_tohost;
    logic [31:0]   r_scratch;
    logic          r_halt;
    logic          r_err;

    // Word-only accesses: byte-lane bits take no part in decode.
    assign w_wordAddr  = {bus.ALUResultM[31:2], 2'b00};
    assign w_unused    = &{1'b0, bus.ALUResultM[1:0]};
    assign w_ramOffset = {1'b0, w_wordAddr} - {1'b0, RAM_BASE};
    assign w_ramIndex  = w_ramOffset[AW+1:2];
    assign w_mmioOff   = {bus.ALUResultM[3:2], 2'b00};

    // The 33-bit offset carries a borrow, so addresses below RAM_BASE never alias into RAM.
    always_comb begin
        w_hit = MISS;
        if (bus.ALUResultM[31:4] == MMIO_BASE[31:4]) begin
            w_hit = HIT_MMIO;
        end else if (!w_ramOffset[32] && (w_ramOffset < RAM_SPAN)) begin
            w_hit = HIT_RAM;
        end
    end

    always_comb begin
        w_storeRam     = bus.MemWriteM && !reset && (w_hit == HIT_RAM);
        w_storeCycle   = bus.MemWriteM && (w_hit == HIT_MMIO) && (w_mmioOff == OFF_CYCLE);
        w_storeTohost  = bus.MemWriteM && (w_hit == HIT_MMIO) && (w_mmioOff == OFF_TOHOST);
        w_storeScratch = bus.MemWriteM && (w_hit == HIT_MMIO) && (w_mmioOff == OFF_SCRATCH);
        w_storeMiss    = bus.MemWriteM && (w_hit == MISS);
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_storeRam),
        .i_index (w_ramIndex),
        .i_wdata (bus.WriteDataM),
        .o_rdata (w_ramRdata)
    );

    // A CYCLE store replaces that edge's increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle <= '0;
        end else if (w_storeCycle) begin
            r_cycle <= bus.WriteDataM;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // First TOHOST store wins; later ones are ignored once halted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tohost <= '0;
            r_halt   <= 1'b0;
        end else if (w_storeTohost && !r_halt) begin
            r_tohost <= bus.WriteDataM;
            r_halt   <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scratch <= '0;
        end else if (w_storeScratch) begin
            r_scratch <= bus.WriteDataM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_storeMiss) begin
            r_err <= 1'b1;
        end
    end

    always_comb begin
        w_readData = '0;
        case (w_hit)
            HIT_RAM:  w_readData = w_ramRdata;
            HIT_MMIO: begin
                case (w_mmioOff)
                    OFF_CYCLE:   w_readData = r_cycle;
                    OFF_TOHOST:  w_readData = r_tohost;
                    OFF_SCRATCH: w_readData = r_scratch;
                    OFF_STATUS:  w_readData = statusWord(r_halt, r_err);
                    default:     w_readData = '0;
                endcase
            end
            default:  w_readData = '0;
        endcase
    end

    assign bus.ReadDataM = w_readData;
    assign halt          = r_halt;
    assign tohost        = r_tohost;
    assign err           = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: RAM, MMIO registers, counter wrap, miss and reset behaviour.
module tb_dmem_responder;

    localparam logic [31:0] MMIO    = 32'h8000_0000;
    localparam logic [31:0] CYCLE   = MMIO + 32'h0;
    localparam logic [31:0] TOHOST  = MMIO + 32'h4;
    localparam logic [31:0] SCRATCH = MMIO + 32'h8;
    localparam logic [31:0] STATUS  = MMIO + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        err;
    logic [31:0] tohost;

    logic [31:0] expQ[$];
    int          checks = 0;
    int          errors = 0;

    dmem_responder_if bus();

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .RAM_BASE    (32'h0000_0000),
        .MMIO_BASE   (MMIO)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .halt   (halt),
        .tohost (tohost),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Each call occupies one cycle: inputs change on the falling edge, outputs settle 1 ns later.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.MemWriteM  = we;
        bus.ALUResultM = addr;
        bus.WriteDataM = data;
        #1;
    endtask

    task automatic pushExp(input logic [31:0] v);
        expQ.push_back(v);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed);
        logic [31:0] expected;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=<scoreboard empty>", tag, observed);
            return;
        end
        expected = expQ.pop_front();
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic expectRead(input string tag, input logic [31:0] v);
        pushExp(v);
        checkOutput(tag, bus.ReadDataM);
    endtask

    task automatic expectBit(input string tag, input logic observed, input logic v);
        pushExp({31'b0, v});
        checkOutput(tag, {31'b0, observed});
    endtask

    initial begin
        reset          = 1'b1;
        bus.MemWriteM  = 1'b0;
        bus.ALUResultM = CYCLE;
        bus.WriteDataM = '0;
        @(posedge clk);
        #1;
        $display("[TB] reset state");
        expectBit("reset_halt", halt, 1'b0);
        expectBit("reset_err", err, 1'b0);
        pushExp(32'h0);
        checkOutput("reset_tohost", tohost);
        expectRead("reset_cycle_read", 32'h0);

        @(negedge clk);
        reset = 1'b0;

        $display("[TB] cycle counter");
        repeat (5) applyStimulus(1'b0, CYCLE, 32'h0);
        expectRead("cycle_after_5", 32'd5);
        applyStimulus(1'b1, CYCLE, 32'hFFFF_FFFE);
        expectRead("cycle_store_same_cycle", 32'd6);
        applyStimulus(1'b0, CYCLE, 32'h0);
        expectRead("cycle_loaded", 32'hFFFF_FFFE);
        applyStimulus(1'b0, CYCLE, 32'h0);
        expectRead("cycle_max", 32'hFFFF_FFFF);
        applyStimulus(1'b0, CYCLE, 32'h0);
        expectRead("cycle_wrap", 32'h0);

        $display("[TB] RAM read-during-write");
        applyStimulus(1'b1, 32'h10, 32'h1111_1111);
        applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF);
        expectRead("ram_same_cycle_old", 32'h1111_1111);
        applyStimulus(1'b0, 32'h10, 32'h0);
        expectRead("ram_next_cycle_new", 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h13, 32'h0);
        expectRead("ram_low_bits_ignored", 32'hDEAD_BEEF);

        applyStimulus(1'b1, SCRATCH, 32'h0000_A5A5);
        applyStimulus(1'b0, SCRATCH, 32'h0);
        expectRead("scratch_rw", 32'h0000_A5A5);

        $display("[TB] TOHOST and STATUS");
        applyStimulus(1'b1, TOHOST, 32'd7);
        expectBit("halt_before_edge", halt, 1'b0);
        applyStimulus(1'b0, TOHOST, 32'h0);
        expectBit("halt_set", halt, 1'b1);
        pushExp(32'd7);
        checkOutput("tohost_captured", tohost);
        applyStimulus(1'b1, TOHOST, 32'd9);
        applyStimulus(1'b0, TOHOST, 32'h0);
        pushExp(32'd7);
        checkOutput("tohost_first_wins", tohost);
        expectRead("tohost_read", 32'd7);
        applyStimulus(1'b1, STATUS, 32'hFFFF_FFFF);
        applyStimulus(1'b0, STATUS, 32'h0);
        expectRead("status_halted", 32'h1);
        expectBit("status_store_no_err", err, 1'b0);
        applyStimulus(1'b1, 32'h20, 32'h55);
        applyStimulus(1'b0, 32'h20, 32'h0);
        expectRead("ram_store_after_halt", 32'h55);

        $display("[TB] RAM boundary");
        applyStimulus(1'b1, 32'h0, 32'hCAFE_F00D);
        applyStimulus(1'b1, 32'h0000_0FFC, 32'h1234);
        applyStimulus(1'b0, 32'h0000_0FFC, 32'h0);
        expectRead("ram_last_word", 32'h1234);
        expectBit("err_before_oob", err, 1'b0);
        applyStimulus(1'b1, 32'h0000_1000, 32'hBAD0_BAD0);
        applyStimulus(1'b0, 32'h0000_1000, 32'h0);
        expectBit("err_oob", err, 1'b1);
        expectRead("oob_read_zero", 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0);
        expectRead("ram_word0_no_alias", 32'hCAFE_F00D);

        $display("[TB] miss store");
        applyStimulus(1'b1, 32'h4000_0000, 32'h0BAD);
        applyStimulus(1'b0, 32'h4000_0000, 32'h0);
        expectRead("miss_read_zero", 32'h0);
        applyStimulus(1'b0, STATUS, 32'h0);
        expectRead("status_halt_err", 32'h3);
        applyStimulus(1'b0, 32'h10, 32'h0);
        expectRead("miss_ram_unchanged", 32'hDEAD_BEEF);
        applyStimulus(1'b0, SCRATCH, 32'h0);
        expectRead("miss_scratch_unchanged", 32'h0000_A5A5);
        applyStimulus(1'b0, MMIO + 32'h10, 32'h0);
        expectRead("mmio_window_end_miss", 32'h0);

        $display("[TB] asynchronous reset mid-store");
        applyStimulus(1'b1, SCRATCH, 32'h5555_5555);
        #2;
        reset = 1'b1;
        #1;
        expectBit("async_halt_clear", halt, 1'b0);
        expectBit("async_err_clear", err, 1'b0);
        pushExp(32'h0);
        checkOutput("async_tohost_clear", tohost);
        expectRead("reset_scratch_read", 32'h0);
        @(negedge clk);
        reset         = 1'b0;
        bus.MemWriteM = 1'b0;
        applyStimulus(1'b0, SCRATCH, 32'h0);
        expectRead("scratch_after_reset", 32'h0);
        applyStimulus(1'b0, CYCLE, 32'h0);
        expectRead("cycle_after_reset", 32'd2);

        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain observed=%0d expected=0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the pipeline's Memory-stage initiator signals: MemWriteM, ALUResultM (address), WriteDataM and ReadDataM.
- Contains a word-addressed RAM and a small MMIO register window:
  - free-running cycle counter,
  - TOHOST halt register,
  - scratch register,
  - status register.
- Reads are combinational within the M cycle, so the Memory/Writeback pipeline flop captures the read data at the next edge.
- Writes commit at the clock edge.

Parameters:
- DEPTH_WORDS, 1024, RAM size in 32-bit words; power of two.
- RAM_BASE, 32'h0000_0000, byte address of RAM word 0.
- MMIO_BASE, 32'h8000_0000, byte address of the MMIO window (16 bytes).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemWriteM  in  1  store request this cycle.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load data, combinational from ALUResultM.
- halt  out  1  sticky; set by the first TOHOST store.
- tohost  out  32  value captured by the first TOHOST store.
- err  out  1  sticky; set by any out-of-range store.

Behaviour:
- Reset: one clock, reset is asynchronous and active-high.
  - halt, err, tohost, scratch and the cycle counter all clear to 0.
  - RAM contents are not reset; simulation preloads them.
  - ReadDataM follows its address decode during reset; MMIO reads return 0.
- Address decode:
  - Accesses are word only; ALUResultM[1:0] are ignored everywhere.
  - RAM hit: RAM_BASE <= addr < RAM_BASE + 4*DEPTH_WORDS.
    - Index = (addr - RAM_BASE) >> 2, using log2(DEPTH_WORDS) bits.
  - MMIO hit: addr[31:4] == MMIO_BASE[31:4]. Offsets:
    - 0x0 CYCLE: read/write.
    - 0x4 TOHOST: read/write.
    - 0x8 SCRATCH: read/write.
    - 0xC STATUS: read-only; bit0 = halt, bit1 = err, other bits 0.
  - Anything else is a miss.
- Reads:
  - ReadDataM is a purely combinational function of ALUResultM and current state; there is no read enable.
  - A miss returns 32'h0.
- Writes:
  - Commit at the rising edge when MemWriteM = 1 and reset = 0.
  - A same-cycle read of the same address returns the old value; the following cycle returns the new value.
  - Store to CYCLE: the counter loads WriteDataM. That edge has no increment.
  - Store to TOHOST while halt = 0: tohost <= WriteDataM and halt <= 1 at the same edge.
    - Stores to TOHOST while halt = 1 are ignored (first value wins).
  - Store to STATUS: ignored; it is not an error.
  - Store on a miss: dropped, err <= 1 (sticky).
  - RAM stores are still accepted after halt.
- Cycle counter:
  - Increments by 1 every edge not in reset, except on a CYCLE store.
  - Wraps from 32'hFFFF_FFFF to 0.
- Simultaneous events: only one access exists per cycle (single port), so the only collision is counter increment vs CYCLE store; the store wins.
- Reset mid-operation:
  - A store presented in a cycle where reset is high is dropped.
  - halt and err clear immediately (asynchronously).
- Latency: read 0 cycles (combinational); write visible 1 cycle after request.

Decomposition:
- Package dmem_pkg holds:
  - MMIO offset constants (OFF_CYCLE = 4'h0, OFF_TOHOST = 4'h4, OFF_SCRATCH = 4'h8, OFF_STATUS = 4'hC),
  - STATUS bit positions,
  - an enum for the decode result (HIT_RAM, HIT_MMIO, MISS).
- One sub-module, dmem_ram:
  - DEPTH_WORDS x 32 array with one asynchronous read port and one synchronous write port,
  - write enable and index supplied by dmem_responder.
- Decode, MMIO registers and the counter stay in the top module.

Test Plan:
- Store 32'hDEADBEEF to 0x10, then load 0x10 in the same cycle and in the next cycle -> old value, then 32'hDEADBEEF. Load 0x13 -> 32'hDEADBEEF (low bits ignored).
- Release reset and hold idle for 5 cycles; load MMIO_BASE+0x0 -> 5. Store 32'hFFFF_FFFE to CYCLE, then load on each of the next 2 cycles -> FFFF_FFFE, then FFFF_FFFF; the cycle after -> 0 (wrap).
- Store 7 to MMIO_BASE+0x4 -> halt = 1 and tohost = 7 after the edge. Store 9 to TOHOST -> tohost stays 7. STATUS read -> 32'h1.
- Store to 0x4000_0000 (miss) -> RAM and MMIO unchanged, err = 1. Load 0x4000_0000 -> 0. STATUS -> 32'h2, or 32'h3 if halted.
- Assert reset asynchronously mid-cycle while MemWriteM = 1 to SCRATCH -> halt, err and tohost drop to 0 immediately. After release, SCRATCH reads 0 and CYCLE reads the number of post-reset edges.
- Store 32'h1234 to the last RAM word (RAM_BASE + 4*DEPTH_WORDS - 4) -> reads back 32'h1234. A store one word past the end -> err = 1 and RAM word 0 unchanged (no aliasing).
